prod_accumulator: RTL and testbench
===================================

PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter LEN, default 8, is the number of products per frame (2..256).
REQ-002 Parameter ACC_W, default 24, is the accumulator width (at least 16).
REQ-003 Parameter CNT_W, default 9, is the width of the beat counter (at least clog2(LEN+1)).
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-006 Port prod_in, input, 16: unsigned product from the upstream 8x8 multiplier.
REQ-007 Port prod_valid, input, 1: prod_in is valid this cycle.
REQ-008 Port prod_last, input, 1: the current beat ends the frame early; qualified by prod_valid.
REQ-009 Port prod_ready, output, 1: the block accepts a beat this cycle.
REQ-010 Port sum_out, output, ACC_W: accumulated frame sum.
REQ-011 Port cnt_out, output, CNT_W: number of beats in the reported frame.
REQ-012 Port ovf_out, output, 1: sticky overflow flag for the reported frame.
REQ-013 Port sum_valid, output, 1: sum_out, cnt_out and ovf_out are valid.
REQ-014 Port sum_ready, input, 1: the downstream stage accepts the result.

Function
REQ-015 The state machine SHALL have three states: IDLE (no beats yet), ACC (at least one beat accumulated) and HOLD (result presented).
REQ-016 prod_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; it is a registered-state decode with no combinational path from sum_ready.
REQ-017 A beat SHALL be accepted when prod_valid and prod_ready are both 1 at a rising edge; prod_in is zero-extended to ACC_W and added to the accumulator.
REQ-018 An accepted beat SHALL increment the beat counter by 1.
REQ-019 An accepted beat SHALL end the frame when the counter reaches LEN or prod_last is 1, whichever occurs first.
REQ-020 On the edge that accepts the ending beat, the state SHALL go to HOLD; sum_valid is 1 from the next cycle and the result includes that beat (latency 1 cycle).
REQ-021 On a non-ending accepted beat the state SHALL go from IDLE to ACC, or remain in ACC.
REQ-022 With no beat accepted in IDLE or ACC, all state SHALL hold; there is no timeout.
REQ-023 In HOLD, sum_out, cnt_out and ovf_out SHALL remain stable while sum_valid is 1 and sum_ready is 0.
REQ-024 In HOLD, when sum_ready is 1, the state SHALL go to IDLE at that edge; the accumulator, counter and overflow flag clear and sum_valid drops next cycle.
REQ-025 The block SHALL have exactly one bubble cycle between frames: prod_ready returns to 1 only in the cycle after the handshake.
REQ-026 If an addition carries out of ACC_W bits, the accumulator SHALL saturate to 2^ACC_W-1 and set the overflow flag, which stays set until the frame is consumed.
REQ-027 Once saturated, further beats SHALL keep the accumulator at its maximum and still increment the counter.
REQ-028 prod_in and prod_last SHALL be ignored when prod_valid is 0.
REQ-029 prod_last is ignored when prod_ready is 0.

Reset
REQ-030 While rst is 1: state becomes IDLE; accumulator, counter, ovf_out, sum_out, cnt_out and sum_valid become 0; prod_ready is 0.
REQ-031 In the first cycle after rst deasserts, prod_ready SHALL be 1.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-033 rst SHALL take priority over any simultaneous handshake.

Verification
REQ-034 Scenario: LEN=8; 8 back-to-back beats of 0x00FF; sum_ready=1 -> one cycle after the 8th beat sum_out=0x0007F8, cnt_out=8, ovf_out=0; the next frame is accepted after one bubble.
REQ-035 Scenario: beats 0x0010, 0x0020, then 0x0030 with prod_last=1 -> sum_out=0x000060, cnt_out=3.
REQ-036 Scenario: complete a frame with sum_ready held 0 for 5 cycles -> outputs stable, prod_ready=0 throughout, no beat is lost once sum_ready=1.
REQ-037 Scenario: ACC_W=16; beats 0xFFFF then 0x0002 with last -> sum_out=0xFFFF, ovf_out=1, cnt_out=2; the next frame starts with ovf_out=0.
REQ-038 Scenario: rst pulsed after 3 beats of a frame, then a fresh 8-beat frame of 0x0001 -> sum_out=0x000008, cnt_out=8 (no residue).
REQ-039 Scenario: random prod_valid gaps and sum_ready back-pressure against a reference model -> every result matches; no duplicated or dropped beats.

Source files
------------

// File: rtl/prod_accumulator.sv
// Frame accumulator for 16-bit unsigned products: sums up to LEN beats (or until
// prod_last), saturates on overflow, and holds the result until downstream accepts it.
module prod_accumulator #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ovf_out,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W-1:0] sum_nxt;
  logic [CNT_W-1:0] cnt_out_nxt;
  logic             ovf_out_nxt;
  logic             valid_nxt;
  logic             ready_nxt;

  logic [SUM_W-1:0] sum_wide;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             frame_end;

  // Next-state and datapath decode; prod_ready is registered from the next state
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    sum_nxt     = sum_out;
    cnt_out_nxt = cnt_out;
    ovf_out_nxt = ovf_out;
    valid_nxt   = sum_valid;

    sum_wide  = SUM_W'(acc) + SUM_W'(prod_in);
    cnt_inc   = cnt + CNT_W'(1);
    accept    = prod_valid && prod_ready;
    frame_end = (cnt_inc == CNT_LEN) || prod_last;

    case (state)
      IDLE, ACC: begin
        if (accept) begin
          // Saturate on carry-out; a saturated accumulator stays pinned at max
          if (ovf || sum_wide[ACC_W]) begin
            acc_nxt = ACC_MAX;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum_wide[ACC_W-1:0];
          end
          cnt_nxt = cnt_inc;
          if (frame_end) begin
            state_nxt   = HOLD;
            sum_nxt     = acc_nxt;
            cnt_out_nxt = cnt_nxt;
            ovf_out_nxt = ovf_nxt;
            valid_nxt   = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_nxt   = IDLE;
          acc_nxt     = '0;
          cnt_nxt     = '0;
          ovf_nxt     = 1'b0;
          sum_nxt     = '0;
          cnt_out_nxt = '0;
          ovf_out_nxt = 1'b0;
          valid_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    ready_nxt = (state_nxt != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      sum_out    <= '0;
      cnt_out    <= '0;
      ovf_out    <= 1'b0;
      sum_valid  <= 1'b0;
      prod_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      ovf        <= ovf_nxt;
      sum_out    <= sum_nxt;
      cnt_out    <= cnt_out_nxt;
      ovf_out    <= ovf_out_nxt;
      sum_valid  <= valid_nxt;
      prod_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed and randomized checks of prod_accumulator; a 24-bit and a 16-bit
// accumulator instance share one stimulus stream.
module tb_prod_accumulator;

  localparam int unsigned LEN   = 8;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned ACC_S = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      prod_in;
  logic             prod_valid;
  logic             prod_last;
  logic             sum_ready;

  logic             prod_ready;
  logic [ACC_W-1:0] sum_out;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf_out;
  logic             sum_valid;

  logic             prod_ready16;
  logic [ACC_S-1:0] sum_out16;
  logic [CNT_W-1:0] cnt_out16;
  logic             ovf_out16;
  logic             sum_valid16;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  prod_accumulator #(.LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready), .sum_out(sum_out),
    .cnt_out(cnt_out), .ovf_out(ovf_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready)
  );

  prod_accumulator #(.LEN(LEN), .ACC_W(ACC_S), .CNT_W(CNT_W)) u_dut16 (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready16), .sum_out(sum_out16),
    .cnt_out(cnt_out16), .ovf_out(ovf_out16), .sum_valid(sum_valid16),
    .sum_ready(sum_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic beat(input logic [15:0] d, input logic l);
    int n = 0;
    prod_valid = 1'b1;
    prod_in    = d;
    prod_last  = l;
    while (!prod_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(prod_ready), 32'd1);
    tick();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [31:0] s, input logic [31:0] c,
                            input logic o);
    chk({tag, "_valid"}, 32'(sum_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum_out), s);
    chk({tag, "_cnt"}, 32'(cnt_out), c);
    chk({tag, "_ovf"}, 32'(ovf_out), 32'(o));
  endtask

  longint m_sum;
  longint e_sum;
  int     m_cnt;
  int     e_cnt;
  bit     m_hold;

  initial begin
    rst        = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    sum_ready  = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(prod_ready), 32'd0);
    chk("rst_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cnt", 32'(cnt_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(prod_ready), 32'd1);

    // 8 back-to-back beats of 0x00FF
    sum_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", 32'(prod_ready), 32'd1);
      beat(16'h00FF, 1'b0);
    end
    chk_result("full", 32'h7F8, 32'd8, 1'b0);
    chk("full_hold_ready", 32'(prod_ready), 32'd0);
    tick();
    chk("bubble_valid", 32'(sum_valid), 32'd0);
    chk("bubble_ready", 32'(prod_ready), 32'd1);

    // Early end via prod_last; an unqualified prod_last in between is ignored
    beat(16'h0010, 1'b0);
    prod_in   = 16'hFFFF;
    prod_last = 1'b1;
    tick();
    prod_last = 1'b0;
    chk("novalid_last", 32'(sum_valid), 32'd0);
    beat(16'h0020, 1'b0);
    beat(16'h0030, 1'b1);
    chk_result("last", 32'h60, 32'd3, 1'b0);
    tick();

    // Back-pressure: result held 5 cycles while a beat waits upstream
    sum_ready = 1'b0;
    beat(16'h0001, 1'b0);
    beat(16'h0002, 1'b1);
    prod_valid = 1'b1;
    prod_in    = 16'h0040;
    for (int i = 0; i < 5; i++) begin
      chk_result("bp", 32'h3, 32'd2, 1'b0);
      chk("bp_ready", 32'(prod_ready), 32'd0);
      tick();
    end
    sum_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(sum_valid), 32'd0);
    chk("bp_release_ready", 32'(prod_ready), 32'd1);
    beat(16'h0040, 1'b0);
    beat(16'h0080, 1'b1);
    chk_result("bp_next", 32'hC0, 32'd2, 1'b0);
    tick();

    // Saturation on the 16-bit instance; 24-bit instance sees the true sum
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b1);
    chk("sat_sum16", 32'(sum_out16), 32'hFFFF);
    chk("sat_ovf16", 32'(ovf_out16), 32'd1);
    chk("sat_cnt16", 32'(cnt_out16), 32'd2);
    chk_result("nosat24", 32'h10001, 32'd2, 1'b0);
    tick();
    beat(16'h8000, 1'b0);
    beat(16'h8000, 1'b0);
    beat(16'h0001, 1'b0);
    beat(16'h0001, 1'b1);
    chk("satkeep_sum16", 32'(sum_out16), 32'hFFFF);
    chk("satkeep_cnt16", 32'(cnt_out16), 32'd4);
    chk("satkeep_ovf16", 32'(ovf_out16), 32'd1);
    tick();
    beat(16'h0005, 1'b1);
    chk("ovf_clear16", 32'(ovf_out16), 32'd0);
    chk("ovf_clear_sum16", 32'(sum_out16), 32'h5);
    tick();

    // Reset mid-frame, with a beat offered on the reset edge
    for (int i = 0; i < 3; i++) beat(16'h0100, 1'b0);
    rst        = 1'b1;
    prod_valid = 1'b1;
    prod_in    = 16'h0777;
    tick();
    prod_valid = 1'b0;
    rst        = 1'b0;
    tick();
    chk("midrst_valid", 32'(sum_valid), 32'd0);
    chk("midrst_ready", 32'(prod_ready), 32'd1);
    for (int i = 0; i < 8; i++) beat(16'h0001, 1'b0);
    chk_result("fresh", 32'h8, 32'd8, 1'b0);
    tick();

    // Reset while holding a result discards it
    sum_ready = 1'b0;
    beat(16'h0009, 1'b1);
    chk("hold_pre_rst", 32'(sum_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst_valid", 32'(sum_valid), 32'd0);
    chk("hold_rst_sum", 32'(sum_out), 32'd0);
    tick();

    // Random gaps and back-pressure against a reference model
    m_hold = 1'b0;
    m_sum  = 0;
    m_cnt  = 0;
    e_sum  = 0;
    e_cnt  = 0;
    for (int i = 0; i < 600; i++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_in    = 16'($urandom);
      prod_last  = ($urandom_range(0, 9) == 0);
      sum_ready  = ($urandom_range(0, 2) != 0);
      if (m_hold) begin
        if (sum_ready) m_hold = 1'b0;
      end else if (prod_valid) begin
        m_sum += longint'(prod_in);
        m_cnt++;
        if (m_cnt == LEN || prod_last) begin
          m_hold = 1'b1;
          e_sum  = m_sum;
          e_cnt  = m_cnt;
          m_sum  = 0;
          m_cnt  = 0;
        end
      end
      tick();
      chk("rnd_valid", 32'(sum_valid), 32'(m_hold));
      chk("rnd_ready", 32'(prod_ready), 32'(!m_hold));
      if (m_hold) begin
        chk("rnd_sum", 32'(sum_out), 32'(e_sum));
        chk("rnd_cnt", 32'(cnt_out), 32'(e_cnt));
        chk("rnd_sum16", 32'(sum_out16), (e_sum > 65535) ? 32'hFFFF : 32'(e_sum));
        chk("rnd_ovf16", 32'(ovf_out16), (e_sum > 65535) ? 32'd1 : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
